// File: rtl/rf_pkg.sv
// Shared register-file definitions for the write-back path and the operand read mux.
package rf_pkg;
  localparam int RF_WIDTH = 16;
  localparam int NUM_REGS = 8;
  localparam logic [2:0] PC_IDX = 3'd7;

  // Write-back FSM: IDLE accepts a request, COMMIT writes it the following edge.
  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } wb_state_e;
endpackage

// File: rtl/wb_decoder3to8.sv
// 3-bit register index to one-hot enable, gated by en.
module wb_decoder3to8 (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] oh
);
  // One bit set when enabled, all zero otherwise.
  always_comb begin
    oh = '0;
    if (en) oh[idx] = 1'b1;
  end
endmodule

// File: rtl/demux16_1to8_wb.sv
// Write-back demux and R0..R7 bank: two-cycle accept/commit, R7 doubles as the PC,
// plus a pending scoreboard of claimed-but-uncommitted destinations.
module demux16_1to8_wb
  import rf_pkg::*;
#(
  parameter int             WIDTH     = RF_WIDTH,
  parameter int             PC_STEP   = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             claim_valid,
  input  logic [2:0]       claim_addr,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic [WIDTH-1:0] reg4,
  output logic [WIDTH-1:0] reg5,
  output logic [WIDTH-1:0] reg6,
  output logic [WIDTH-1:0] reg7,
  output logic [7:0]       pending
);
  typedef struct packed {
    logic [2:0]       addr;
    logic [WIDTH-1:0] data;
  } wb_req_t;

  wb_state_e                        state;
  wb_req_t                          hold;
  logic [NUM_REGS-1:0][WIDTH-1:0]   rf;
  logic [NUM_REGS-1:0]              commit_oh;
  logic [NUM_REGS-1:0]              claim_oh;

  assign wr_ready = (state == IDLE);

  wb_decoder3to8 u_dec_commit (
    .en  (state == COMMIT),
    .idx (hold.addr),
    .oh  (commit_oh)
  );

  wb_decoder3to8 u_dec_claim (
    .en  (claim_valid),
    .idx (claim_addr),
    .oh  (claim_oh)
  );

  // Accept in IDLE, commit unconditionally on the next edge; inputs ignored in COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
    end else if (state == IDLE) begin
      if (wr_valid) begin
        hold  <= '{addr: wr_addr, data: wr_data};
        state <= COMMIT;
      end
    end else begin
      state <= IDLE;
    end
  end

  // Per-register update; a commit to the PC register overrides the increment.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam bit IS_PC = (i == int'(PC_IDX));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                rf[i] <= RESET_VAL;
      else if (commit_oh[i])     rf[i] <= hold.data;
      else if (IS_PC && pc_inc)  rf[i] <= rf[i] + WIDTH'(PC_STEP);
    end
  end

  // Commit clears, claim sets; a same-index claim is newer so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~commit_oh) | claim_oh;
  end

  assign reg0 = rf[0];
  assign reg1 = rf[1];
  assign reg2 = rf[2];
  assign reg3 = rf[3];
  assign reg4 = rf[4];
  assign reg5 = rf[5];
  assign reg6 = rf[6];
  assign reg7 = rf[7];
endmodule

// File: tb/tb_demux16_1to8_wb.sv
// Directed bench for the write-back demux / register bank.
module tb_demux16_1to8_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        claim_valid = 1'b0;
  logic [2:0]  claim_addr = '0;
  logic        pc_inc = 1'b0;
  logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [7:0]  pending;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  demux16_1to8_wb dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .pc_inc(pc_inc),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
    .pending(pending)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset mid-cycle, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_reg0", reg0, 16'h0000);
    chk("rst_reg3", reg3, 16'h0000);
    chk("rst_reg7", reg7, 16'h0000);
    chk("rst_pending", {8'h00, pending}, 16'h0000);
    chk("rst_ready", {15'd0, wr_ready}, 16'h0001);
    tick();
    rst_n = 1'b1;
    tick();

    // Single write to R3
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5;
    tick();
    wr_valid = 1'b0;
    chk("w3_ready_busy", {15'd0, wr_ready}, 16'h0000);
    chk("w3_not_yet", reg3, 16'h0000);
    tick();
    chk("w3_reg3", reg3, 16'hA5A5);
    chk("w3_ready_back", {15'd0, wr_ready}, 16'h0001);
    chk("w3_reg2", reg2, 16'h0000);
    chk("w3_reg4", reg4, 16'h0000);

    // Back-to-back with wr_valid held; addr/data change during COMMIT is ignored
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
    tick();
    chk("b2b_busy1", {15'd0, wr_ready}, 16'h0000);
    wr_addr = 3'd2; wr_data = 16'h2222;
    tick();
    chk("b2b_reg1", reg1, 16'h1111);
    chk("b2b_reg2_pre", reg2, 16'h0000);
    chk("b2b_ready", {15'd0, wr_ready}, 16'h0001);
    tick();
    chk("b2b_busy2", {15'd0, wr_ready}, 16'h0000);
    wr_valid = 1'b0;
    tick();
    chk("b2b_reg2", reg2, 16'h2222);
    chk("b2b_reg1_keep", reg1, 16'h1111);
    chk("b2b_reg3_keep", reg3, 16'hA5A5);

    // PC wrap
    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("pc_load", reg7, 16'hFFFF);
    pc_inc = 1'b1;
    tick();
    chk("pc_wrap", reg7, 16'h0000);
    tick();
    chk("pc_inc1", reg7, 16'h0001);
    pc_inc = 1'b0;

    // Commit to R7 collides with pc_inc: data wins
    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 16'h0040;
    tick();
    wr_valid = 1'b0; pc_inc = 1'b1;
    chk("pc_hold", reg7, 16'h0001);
    tick();
    pc_inc = 1'b0;
    chk("pc_collide", reg7, 16'h0040);

    // Scoreboard
    claim_valid = 1'b1; claim_addr = 3'd5;
    tick();
    claim_valid = 1'b0;
    chk("sb_claim5", {8'h00, pending}, 16'h0020);
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
    tick();
    wr_valid = 1'b0;
    chk("sb_accepted", {8'h00, pending}, 16'h0020);
    tick();
    chk("sb_commit5", {8'h00, pending}, 16'h0000);
    chk("sb_reg5", reg5, 16'h5555);
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'h6666;
    tick();
    wr_valid = 1'b0; claim_valid = 1'b1; claim_addr = 3'd5;
    tick();
    claim_valid = 1'b0;
    chk("sb_same_idx", {8'h00, pending}, 16'h0020);
    chk("sb_reg5b", reg5, 16'h6666);
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'h7777;
    tick();
    wr_valid = 1'b0; claim_valid = 1'b1; claim_addr = 3'd2;
    tick();
    claim_valid = 1'b0;
    chk("sb_diff_idx", {8'h00, pending}, 16'h0004);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 16'h0F0F;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("sb_unclaimed", {8'h00, pending}, 16'h0004);
    chk("sb_reg0", reg0, 16'h0F0F);

    // Reset during COMMIT discards the held write
    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 16'h1234;
    tick();
    wr_valid = 1'b0;
    chk("mid_busy", {15'd0, wr_ready}, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reg4", reg4, 16'h0000);
    chk("mid_ready", {15'd0, wr_ready}, 16'h0001);
    chk("mid_pending", {8'h00, pending}, 16'h0000);
    chk("mid_reg5", reg5, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_reg4", reg4, 16'h0000);
    chk("post_ready", {15'd0, wr_ready}, 16'h0001);
    chk("post_reg7", reg7, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
